hack_data_mem: RTL
==================

HACK_DATA_MEM -- requirements
Module: hack_data_mem

Interface
REQ-001 Parameter: RAM_WORDS, default 16384, number of general RAM words at 0x0000-0x3FFF.
REQ-002 Parameter: SCR_WORDS, default 8192, number of screen words at 0x4000-0x5FFF.
REQ-003 Parameter: KBD_ADDR, default 15'h6000, keyboard register address.
REQ-004 Port: clk_i, input, 1, single clock; all state updates on rising edge.
REQ-005 Port: reset_n_i, input, 1, asynchronous active-low reset.
REQ-006 Port: addr_i, input, 15, CPU data address (addressM).
REQ-007 Port: data_i, input, 16, CPU write data (outM).
REQ-008 Port: wr_en_i, input, 1, CPU write enable (writeM).
REQ-009 Port: data_o, output, 16, read data to CPU (inM).
REQ-010 Port: kbd_code_i, input, 16, key scan code from the keyboard front end; 0 means no key.
REQ-011 Port: kbd_stb_i, input, 1, key-change strobe, not synchronous to clk_i.
REQ-012 Port: scr_addr_i, input, 13, display scan-out word address.
REQ-013 Port: scr_data_o, output, 16, display scan-out word.
REQ-014 Port: frame_i, input, 1, one-cycle frame-start pulse from the display timer.
REQ-015 Port: scr_dirty_o, output, 1, screen written since last frame start.
REQ-016 Port: oob_cnt_o, output, 8, count of out-of-range CPU writes.

Function
REQ-017 CPU read path SHALL be combinational: data_o reflects addr_i in the same cycle (zero latency).
REQ-018 Decode: addr < 0x4000 -> RAM; 0x4000-0x5FFF -> screen; addr == KBD_ADDR -> keyboard; all other addresses -> out-of-range.
REQ-019 A RAM or screen write SHALL occur at the rising edge when wr_en_i=1; the written value is visible on data_o from the next cycle.
REQ-020 Read data SHALL be 16'h0000 for out-of-range addresses.
REQ-021 Writes to KBD_ADDR SHALL be ignored; the keyboard register is read-only.
REQ-022 kbd_stb_i SHALL pass through a 2-flop synchronizer plus an edge-detect flop.
REQ-023 On each synchronized rising edge of kbd_stb_i, kbd_code_i SHALL be captured into the keyboard register.
REQ-024 Keyboard capture latency SHALL be 3 cycles from the strobe edge to the new value on data_o at KBD_ADDR.
REQ-025 The screen SHALL have a second, independent read port: scr_data_o = screen[scr_addr_i], registered, 1-cycle latency.
REQ-026 A scan port read of a word written in the same cycle SHALL return the old data (read-before-write).
REQ-027 scr_dirty_o SHALL set on any screen write and clear on frame_i.
REQ-028 When a screen write and frame_i coincide, the set SHALL win (scr_dirty_o=1).
REQ-029 oob_cnt_o SHALL increment on each wr_en_i=1 cycle with an out-of-range address, including KBD_ADDR writes, and SHALL saturate at 8'hFF.
REQ-030 wr_en_i=0 SHALL never modify any storage, counter or flag.

Reset
REQ-031 Asserting reset_n_i low SHALL immediately clear the keyboard register, synchronizer/edge flops, scr_data_o, scr_dirty_o and oob_cnt_o to 0, regardless of clk_i.
REQ-032 RAM and screen contents SHALL NOT be cleared by reset; data_o follows array contents after reset.
REQ-033 A strobe edge whose synchronization is in progress when reset asserts SHALL be discarded; the keyboard register reads 0 after release.
REQ-034 The first capture after reset release SHALL require a fresh synchronized rising edge of kbd_stb_i.

Verification
REQ-035 RAM write/read: write 16'h1234 to 0x0010 -> data_o=16'h1234 at addr 0x0010 on the next cycle; same-cycle read still shows the old word.
REQ-036 Screen dual port: write 16'hFFFF to 0x4005 with scr_addr_i=5 in the same cycle -> scr_data_o shows the old value, then 16'hFFFF one cycle later; scr_dirty_o=1.
REQ-037 Keyboard: kbd_code_i=16'd75, pulse kbd_stb_i -> data_o at 0x6000 reads 75 exactly 3 cycles after the edge; a write of 16'h9999 to 0x6000 leaves 75 and increments oob_cnt_o.
REQ-038 Out-of-range: 300 writes to 0x7000 -> oob_cnt_o=8'hFF; reads from 0x7000 return 0.
REQ-039 Dirty collision: screen write and frame_i in the same cycle -> scr_dirty_o=1; frame_i alone next cycle -> scr_dirty_o=0.
REQ-040 Reset mid-operation: assert reset_n_i low between clock edges one cycle after a kbd_stb_i edge -> keyboard register=0, oob_cnt_o=0, RAM word 0x0010 still reads 16'h1234.

Source files
------------

// File: rtl/hack_data_mem.sv
// hack_data_mem: Hack computer data memory map.
//   0x0000..RAM_WORDS-1        general RAM (combinational read, clocked write)
//   0x4000..0x4000+SCR_WORDS-1 screen RAM, plus a registered scan-out read port
//   KBD_ADDR                   read-only keyboard register fed by an async strobe
//   anything else              out of range: reads 0, writes are counted
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   addr_i, data_i, wr_en_i CPU address / write data / write enable
//   data_o                  CPU read data (zero latency)
//   kbd_code_i, kbd_stb_i   key scan code and asynchronous key-change strobe
//   scr_addr_i, scr_data_o  display scan-out address / registered word
//   frame_i, scr_dirty_o    frame-start pulse / screen-written-this-frame flag
//   oob_cnt_o               saturating count of out-of-range writes
module hack_data_mem #(
  parameter int         RAM_WORDS = 16384,
  parameter int         SCR_WORDS = 8192,
  parameter logic [14:0] KBD_ADDR = 15'h6000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [14:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        wr_en_i,
  output logic [15:0] data_o,
  input  logic [15:0] kbd_code_i,
  input  logic        kbd_stb_i,
  input  logic [12:0] scr_addr_i,
  output logic [15:0] scr_data_o,
  input  logic        frame_i,
  output logic        scr_dirty_o,
  output logic [7:0]  oob_cnt_o
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCR_WORDS);

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] scr [SCR_WORDS];

  logic [14:0] scr_off;
  logic        is_ram;
  logic        is_scr;
  logic        is_kbd;
  logic        ram_we;
  logic        scr_we;
  logic        oob_we;

  logic        stb_meta;
  logic        stb_sync;
  logic        stb_prev;
  logic        stb_rise;
  logic [15:0] kbd_reg;

  // Address decode; RAM has priority, then screen, then keyboard.
  always_comb begin
    scr_off = addr_i - 15'h4000;
    is_ram  = (32'(addr_i) < 32'(RAM_WORDS));
    is_scr  = !is_ram && (addr_i >= 15'h4000) && (32'(scr_off) < 32'(SCR_WORDS));
    is_kbd  = !is_ram && !is_scr && (addr_i == KBD_ADDR);
    ram_we  = wr_en_i && is_ram;
    scr_we  = wr_en_i && is_scr;
    // Keyboard writes land here too: the register is read-only.
    oob_we  = wr_en_i && !is_ram && !is_scr;
  end

  // CPU read mux, zero latency.
  always_comb begin
    data_o = 16'h0000;
    if (is_ram) begin
      data_o = ram[addr_i[RAM_AW-1:0]];
    end else if (is_scr) begin
      // Screen base 0x4000 is aligned, so the low bits are the word offset.
      data_o = scr[addr_i[SCR_AW-1:0]];
    end else if (is_kbd) begin
      data_o = kbd_reg;
    end else begin
      data_o = 16'h0000;
    end
  end

  // RAM and screen storage; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      ram[addr_i[RAM_AW-1:0]] <= data_i;
    end
    if (scr_we) begin
      scr[addr_i[SCR_AW-1:0]] <= data_i;
    end
  end

  // Scan-out port: old word is returned when the CPU writes the same word.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scr_data_o <= 16'h0000;
    end else begin
      scr_data_o <= scr[scr_addr_i[SCR_AW-1:0]];
    end
  end

  assign stb_rise = stb_sync && !stb_prev;

  // Strobe synchronizer, edge detect and keyboard capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stb_meta <= 1'b0;
      stb_sync <= 1'b0;
      stb_prev <= 1'b0;
      kbd_reg  <= 16'h0000;
    end else begin
      stb_meta <= kbd_stb_i;
      stb_sync <= stb_meta;
      stb_prev <= stb_sync;
      if (stb_rise) begin
        kbd_reg <= kbd_code_i;
      end
    end
  end

  // Dirty flag: a write in the frame-start cycle keeps it set.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scr_dirty_o <= 1'b0;
    end else if (scr_we) begin
      scr_dirty_o <= 1'b1;
    end else if (frame_i) begin
      scr_dirty_o <= 1'b0;
    end
  end

  // Saturating out-of-range write counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      oob_cnt_o <= 8'h00;
    end else if (oob_we && (oob_cnt_o != 8'hFF)) begin
      oob_cnt_o <= oob_cnt_o + 8'h01;
    end
  end

endmodule
